led_fader: RTL

LED_FADER -- requirements
Module: led_fader

---
 rtl/led_fader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/led_fader.sv
// Four-channel LED fader: accepts a 4-bit target pattern and ramps each LED's
// PWM brightness toward fully on or fully off in saturating steps.
module led_fader #(
  parameter int unsigned PRESCALE = 390,
  parameter int unsigned STEP     = 16,
  parameter int unsigned FADE_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_bits,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] leds
);

  localparam int unsigned N_LEDS = 4;
  localparam int unsigned BR_W   = 8;
  localparam int unsigned SUM_W  = BR_W + 1;
  localparam int unsigned PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned FD_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [FD_W-1:0]  FD_LAST  = FD_W'(FADE_DIV - 1);
  localparam logic [BR_W-1:0]  BR_MAX   = BR_W'(255);
  localparam logic [SUM_W-1:0] STEP_EXT = SUM_W'(STEP);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FADE = 1'b1
  } state_e;

  state_e                        state_q, state_d;
  logic [PRE_W-1:0]              pre_cnt_q, pre_cnt_d;
  logic [BR_W-1:0]               pwm_cnt_q, pwm_cnt_d;
  logic [FD_W-1:0]               fade_div_cnt_q, fade_div_cnt_d;
  logic [N_LEDS-1:0][BR_W-1:0]   bright_q, bright_d;
  logic [N_LEDS-1:0]             tgt_q, tgt_d;
  logic [N_LEDS-1:0]             leds_q, leds_d;
  logic                          in_ready_q, in_ready_d;

  logic                          tick;
  logic                          period_end;
  logic                          at_target;
  logic [N_LEDS-1:0][SUM_W-1:0]  sum_up;
  logic [N_LEDS-1:0][SUM_W-1:0]  sum_dn;
  logic [N_LEDS-1:0][BR_W-1:0]   bright_step;

  // Free-running prescaler and PWM phase counter
  always_comb begin
    tick       = (pre_cnt_q == PRE_LAST);
    period_end = tick && (pwm_cnt_q == BR_MAX);
    pre_cnt_d  = tick ? '0 : pre_cnt_q + PRE_W'(1);
    pwm_cnt_d  = tick ? pwm_cnt_q + BR_W'(1) : pwm_cnt_q;
  end

  // Saturating next brightness per LED and endpoint detection
  always_comb begin
    at_target = 1'b1;
    for (int i = 0; i < int'(N_LEDS); i++) begin
      sum_up[i] = {1'b0, bright_q[i]} + STEP_EXT;
      sum_dn[i] = {1'b0, bright_q[i]} - STEP_EXT;
      if (tgt_q[i]) begin
        bright_step[i] = sum_up[i][BR_W] ? BR_MAX : sum_up[i][BR_W-1:0];
      end else begin
        bright_step[i] = sum_dn[i][BR_W] ? '0 : sum_dn[i][BR_W-1:0];
      end
      if (bright_q[i] != (tgt_q[i] ? BR_MAX : '0)) begin
        at_target = 1'b0;
      end
    end
  end

  // Control FSM: capture in IDLE, step brightness in FADE until all LEDs settle
  always_comb begin
    state_d        = state_q;
    tgt_d          = tgt_q;
    fade_div_cnt_d = fade_div_cnt_q;
    bright_d       = bright_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d        = ST_FADE;
          tgt_d          = in_bits;
          fade_div_cnt_d = '0;
        end
      end
      ST_FADE: begin
        if (period_end) begin
          if (fade_div_cnt_q == FD_LAST) begin
            fade_div_cnt_d = '0;
            bright_d       = bright_step;
          end else begin
            fade_div_cnt_d = fade_div_cnt_q + FD_W'(1);
          end
        end
        if (at_target) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // Full brightness is forced solid because an 8-bit compare tops out at 255/256
  always_comb begin
    leds_d = '0;
    for (int i = 0; i < int'(N_LEDS); i++) begin
      leds_d[i] = (bright_q[i] == BR_MAX) || (pwm_cnt_q < bright_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      fade_div_cnt_q <= '0;
      bright_q       <= '0;
      tgt_q          <= '0;
      leds_q         <= '0;
      in_ready_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      fade_div_cnt_q <= fade_div_cnt_d;
      bright_q       <= bright_d;
      tgt_q          <= tgt_d;
      leds_q         <= leds_d;
      in_ready_q     <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign leds     = leds_q;

endmodule
